rate_monitor: RTL



---
 rtl/rate_monitor_if.sv | 23 ++
 rtl/rate_monitor.sv | 73 +++++++
 2 files changed

// File: rtl/rate_monitor_if.sv
// rate_monitor_if: monitoring strobes in, rate/elapsed/stall status out
interface rate_monitor_if #(
  parameter int COUNT_WIDTH = 32,
  parameter int SEC_WIDTH = 16
);
  logic enable_i;
  logic clear_i;
  logic second_tick_i;
  logic event_i;
  logic [COUNT_WIDTH-1:0] rate_o;
  logic rate_valid_o;
  logic [SEC_WIDTH-1:0] elapsed_s_o;
  logic timeout_o;
  logic busy_o;
  modport master (
    output enable_i, clear_i, second_tick_i, event_i,
    input rate_o, rate_valid_o, elapsed_s_o, timeout_o, busy_o
  );
  modport slave (
    input enable_i, clear_i, second_tick_i, event_i,
    output rate_o, rate_valid_o, elapsed_s_o, timeout_o, busy_o
  );
endinterface

// File: rtl/rate_monitor.sv
// rate_monitor: windowed operation rate, elapsed seconds and sticky stall flag
module rate_monitor #(
  parameter int COUNT_WIDTH = 32,
  parameter int SEC_WIDTH = 16,
  parameter int WINDOW_S = 1,
  parameter int TIMEOUT_S = 10
) (
  input logic clk,
  input logic rst_i,
  rate_monitor_if.slave bus
);
  localparam int WW = WINDOW_S > 1 ? $clog2(WINDOW_S) : 1;
  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;
  state_t state, state_nx;
  logic [COUNT_WIDTH-1:0] acc, acc_nx;
  logic [WW-1:0] win;
  logic [SEC_WIDTH-1:0] idle_s, idle_nx, el_nx;
  logic seen, measuring, closing;
  always_comb begin
    state_nx = state;
    if (!bus.enable_i) state_nx = IDLE;
    else if (bus.clear_i || state == IDLE) state_nx = ARMED;
    else if (state == ARMED && bus.second_tick_i) state_nx = MEASURE;
  end
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  assign measuring = state == MEASURE && bus.enable_i && !bus.clear_i;
  assign closing = measuring && bus.second_tick_i && win == WW'(WINDOW_S - 1);
  assign acc_nx = &acc ? acc : acc + COUNT_WIDTH'(bus.event_i);
  assign el_nx = &bus.elapsed_s_o ? bus.elapsed_s_o : bus.elapsed_s_o + SEC_WIDTH'(1);
  // activity anywhere in the second, including on the tick itself, restarts the stall count
  assign idle_nx = (seen || bus.event_i) ? '0 :
                   idle_s == SEC_WIDTH'(TIMEOUT_S) ? idle_s : idle_s + SEC_WIDTH'(1);
  assign bus.busy_o = state == MEASURE;
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      acc <= '0;
      win <= '0;
      idle_s <= '0;
      seen <= 1'b0;
      bus.rate_o <= '0;
      bus.rate_valid_o <= 1'b0;
      bus.elapsed_s_o <= '0;
      bus.timeout_o <= 1'b0;
    end else begin
      bus.rate_valid_o <= 1'b0;
      if (bus.clear_i) begin
        bus.rate_o <= '0;
        bus.elapsed_s_o <= '0;
        bus.timeout_o <= 1'b0;
      end
      if (!measuring) begin
        acc <= '0;
        win <= '0;
        idle_s <= '0;
        seen <= 1'b0;
      end else begin
        acc <= closing ? '0 : acc_nx;
        seen <= !bus.second_tick_i && (seen || bus.event_i);
        if (bus.second_tick_i) begin
          bus.elapsed_s_o <= el_nx;
          win <= closing ? '0 : win + WW'(1);
          idle_s <= idle_nx;
          if (idle_nx == SEC_WIDTH'(TIMEOUT_S)) bus.timeout_o <= 1'b1;
        end else if (bus.event_i) idle_s <= '0;
        if (closing) begin
          bus.rate_o <= acc_nx;
          bus.rate_valid_o <= 1'b1;
        end
      end
    end
endmodule
